// File: rtl/ws2812b_pkg.sv
// Shared types and 50 MHz timing defaults for the WS2812B pixel serializer.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    // Rounds up so that a fractional count never shortens a WS2812B timing window.
    function automatic int unsigned ns_to_clks(input int unsigned ns, input int unsigned clk_hz);
        logic [63:0] prod;
        prod = 64'(ns) * 64'(clk_hz);
        return 32'((prod + 64'd999_999_999) / 64'd1_000_000_000);
    endfunction

    localparam int unsigned CLK_HZ_DEF          = 50_000_000;
    localparam int unsigned BIT_PERIOD_CLKS_DEF = ns_to_clks(1250, CLK_HZ_DEF);
    localparam int unsigned T0H_CLKS_DEF        = ns_to_clks(400, CLK_HZ_DEF);
    localparam int unsigned T1H_CLKS_DEF        = ns_to_clks(800, CLK_HZ_DEF);
    localparam int unsigned LATCH_CLKS_DEF      = ns_to_clks(52_000, CLK_HZ_DEF);

endpackage

// File: rtl/ws2812b_bit_timer.sv
// Phase counter and high-time compare for one NRZ code bit.
module ws2812b_bit_timer
    import ws2812b_pkg::*;
#(
    parameter int unsigned BIT_PERIOD_CLKS = BIT_PERIOD_CLKS_DEF,
    parameter int unsigned T0H_CLKS        = T0H_CLKS_DEF,
    parameter int unsigned T1H_CLKS        = T1H_CLKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic bit_value,
    output logic line_high,
    output logic bit_end
);

    localparam int unsigned PW = $clog2(BIT_PERIOD_CLKS);

    logic [PW-1:0] phase;

    assign bit_end   = run && (phase == PW'(BIT_PERIOD_CLKS - 1));
    assign line_high = run && (phase < (bit_value ? PW'(T1H_CLKS) : PW'(T0H_CLKS)));

    // Phase parks at zero outside SHIFT so every pixel starts on a fresh bit boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (!run || bit_end) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/ws2812b_pixel_serializer.sv
// Serialises handshaked pixel words MSB-first as WS2812B NRZ codes, then emits the latch period.
module ws2812b_pixel_serializer
    import ws2812b_pkg::*;
#(
    parameter int unsigned BITS_PER_PIXEL  = 24,
    parameter int unsigned BIT_PERIOD_CLKS = BIT_PERIOD_CLKS_DEF,
    parameter int unsigned T0H_CLKS        = T0H_CLKS_DEF,
    parameter int unsigned T1H_CLKS        = T1H_CLKS_DEF,
    parameter int unsigned LATCH_CLKS      = LATCH_CLKS_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [BITS_PER_PIXEL-1:0] pixel_data,
    input  logic                      pixel_last,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    output logic                      dout,
    output logic                      busy,
    output logic                      underflow,
    output logic                      frame_done
);

    if (!(T0H_CLKS >= 1 && T0H_CLKS < T1H_CLKS && T1H_CLKS < BIT_PERIOD_CLKS &&
          LATCH_CLKS >= BIT_PERIOD_CLKS && BITS_PER_PIXEL >= 2)) begin : g_param_check
        $error("ws2812b_pixel_serializer: illegal timing or pixel width parameters");
    end

    localparam int unsigned IW = $clog2(BITS_PER_PIXEL);
    localparam int unsigned LW = $clog2(LATCH_CLKS);

    state_t                    state;
    state_t                    state_next;
    logic [BITS_PER_PIXEL-1:0] shreg;
    logic [IW-1:0]             bit_idx;
    logic [LW-1:0]             latch_cnt;
    logic                      last_flag;
    logic                      armed;
    logic                      shifting;
    logic                      line_high;
    logic                      bit_end;
    logic                      final_cycle;
    logic                      latch_end;
    logic                      accept;
    logic                      underflow_next;
    logic                      frame_done_next;

    ws2812b_bit_timer #(
        .BIT_PERIOD_CLKS (BIT_PERIOD_CLKS),
        .T0H_CLKS        (T0H_CLKS),
        .T1H_CLKS        (T1H_CLKS)
    ) u_bit_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (shifting),
        .bit_value (shreg[BITS_PER_PIXEL-1]),
        .line_high (line_high),
        .bit_end   (bit_end)
    );

    assign shifting    = (state == SHIFT);
    assign busy        = (state != IDLE);
    assign final_cycle = bit_end && (bit_idx == '0);
    assign latch_end   = (state == LATCH) && (latch_cnt == LW'(LATCH_CLKS - 1));

    // armed keeps ready low through reset and sets on the first edge after release.
    assign pixel_ready = armed && ((state == IDLE) || (final_cycle && !last_flag));
    assign accept      = pixel_valid && pixel_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        underflow_next  = 1'b0;
        frame_done_next = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (final_cycle) begin
                    if (last_flag) begin
                        state_next = LATCH;
                    end else if (!accept) begin
                        state_next     = IDLE;
                        underflow_next = 1'b1;
                    end
                end
            end
            LATCH: begin
                if (latch_end) begin
                    state_next      = IDLE;
                    frame_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed      <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            last_flag  <= 1'b0;
            latch_cnt  <= '0;
            dout       <= 1'b0;
            underflow  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            armed      <= 1'b1;
            dout       <= line_high;
            underflow  <= underflow_next;
            frame_done <= frame_done_next;

            // A back-to-back accept lands on the final bit edge and wins over the shift.
            if (accept) begin
                shreg     <= pixel_data;
                bit_idx   <= IW'(BITS_PER_PIXEL - 1);
                last_flag <= pixel_last;
            end else if (bit_end && (bit_idx != '0)) begin
                shreg   <= {shreg[BITS_PER_PIXEL-2:0], 1'b0};
                bit_idx <= bit_idx - 1'b1;
            end

            if (state == LATCH && !latch_end) begin
                latch_cnt <= latch_cnt + 1'b1;
            end else begin
                latch_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812b_pixel_serializer.sv
// Self-checking bench: per-cycle comparison of the serializer against an NRZ waveform model.
module tb_ws2812b_pixel_serializer;

    localparam int BP = 63;
    localparam int T0 = 20;
    localparam int T1 = 40;
    localparam int LT = 2600;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] data;
    logic        last;
    logic        valid;
    logic        sel;

    logic ready_a, dout_a, busy_a, uf_a, fd_a;
    logic ready_b, dout_b, busy_b, uf_b, fd_b;
    logic ready_o, dout_o, busy_o, uf_o, fd_o;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] px [4];

    always #5 clk = ~clk;

    ws2812b_pixel_serializer #(.BITS_PER_PIXEL(24)) dut24 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pixel_data  (data[23:0]),
        .pixel_last  (last),
        .pixel_valid (valid && !sel),
        .pixel_ready (ready_a),
        .dout        (dout_a),
        .busy        (busy_a),
        .underflow   (uf_a),
        .frame_done  (fd_a)
    );

    ws2812b_pixel_serializer #(.BITS_PER_PIXEL(32)) dut32 (
        .clk         (clk),
        .reset_n     (reset_n),
        .pixel_data  (data),
        .pixel_last  (last),
        .pixel_valid (valid && sel),
        .pixel_ready (ready_b),
        .dout        (dout_b),
        .busy        (busy_b),
        .underflow   (uf_b),
        .frame_done  (fd_b)
    );

    assign ready_o = sel ? ready_b : ready_a;
    assign dout_o  = sel ? dout_b  : dout_a;
    assign busy_o  = sel ? busy_b  : busy_a;
    assign uf_o    = sel ? uf_b    : uf_a;
    assign fd_o    = sel ? fd_b    : fd_a;

    // Drives px[0..n-1] with valid held high and checks every cycle until the frame ends.
    task automatic run_frame(input int w, input int n, input bit fin_last, input bit hold,
                             input string name);
        bit line[$];
        int L, end_t, idx, fails_here, per_px;
        bit bv, acc, e_dout, e_ready, e_busy, e_fd, e_uf;
        line.delete();
        for (int i = 0; i < n; i++) begin
            for (int b = w; b > 0; b--) begin
                bv = px[i][b-1];
                for (int p = 0; p < BP; p++) line.push_back(p < (bv ? T1 : T0));
            end
        end
        per_px     = w * BP;
        L          = n * per_px;
        end_t      = fin_last ? L + LT : L;
        idx        = 0;
        fails_here = 0;
        valid      = 1'b1;
        data       = px[0];
        last       = (n == 1) ? fin_last : 1'b0;
        vectors++;
        if (ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL %s start_ready got %b want 1", name, ready_o);
        end
        acc = valid && ready_o;
        for (int t = 0; t <= end_t; t++) begin
            @(posedge clk);
            if (acc) begin
                idx++;
                #1;
                if (idx < n) begin
                    data = px[idx];
                    last = (idx == n - 1) ? fin_last : 1'b0;
                end else if (hold) begin
                    data = $urandom;
                    last = 1'b0;
                end else begin
                    valid = 1'b0;
                    data  = $urandom;
                end
            end else if (hold && idx >= n) begin
                #1;
                data = $urandom;
                last = 1'($urandom);
            end
            @(negedge clk);
            e_dout  = (t >= 1 && t <= L) ? line[t-1] : 1'b0;
            e_busy  = (t < end_t);
            e_fd    = fin_last && (t == end_t);
            e_uf    = !fin_last && (t == end_t);
            if (t == end_t) e_ready = 1'b1;
            else if ((t + 1) % per_px == 0 && (t + 1) <= L)
                e_ready = ((t + 1) / per_px < n) || !fin_last;
            else e_ready = 1'b0;

            vectors++;
            if (dout_o !== e_dout) begin
                miscompares++; fails_here++;
                $display("FAIL %s dout t=%0d got %b want %b", name, t, dout_o, e_dout);
            end
            vectors++;
            if (ready_o !== e_ready) begin
                miscompares++; fails_here++;
                $display("FAIL %s ready t=%0d got %b want %b", name, t, ready_o, e_ready);
            end
            vectors++;
            if (busy_o !== e_busy) begin
                miscompares++; fails_here++;
                $display("FAIL %s busy t=%0d got %b want %b", name, t, busy_o, e_busy);
            end
            vectors++;
            if (fd_o !== e_fd) begin
                miscompares++; fails_here++;
                $display("FAIL %s frame_done t=%0d got %b want %b", name, t, fd_o, e_fd);
            end
            vectors++;
            if (uf_o !== e_uf) begin
                miscompares++; fails_here++;
                $display("FAIL %s underflow t=%0d got %b want %b", name, t, uf_o, e_uf);
            end
            acc = valid && ready_o && (t < end_t);
            if (fails_here > 6) break;
        end
        valid = 1'b0;
        last  = 1'b0;
        vectors++;
        if (idx !== n) begin
            miscompares++;
            $display("FAIL %s accept_count got %0d want %0d", name, idx, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({ready_a, dout_a, busy_a, uf_a, fd_a, ready_b, dout_b, busy_b, uf_b, fd_b} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 0", {ready_a, dout_a, busy_a, uf_a, fd_a,
                                                          ready_b, dout_b, busy_b, uf_b, fd_b});
        end
        reset_n = 1'b1;
        #1;
        vectors++;
        if (ready_a !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_before_edge got %b want 0", ready_a);
        end
        @(negedge clk);
        vectors++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_after_edge got %b%b want 11", ready_a, ready_b);
        end
    endtask

    task automatic test_single();
        px[0] = 32'hA50F00;
        run_frame(24, 1, 1'b1, 1'b0, "single");
    endtask

    task automatic test_back_to_back();
        px[0] = 32'hFFFFFF;
        px[1] = 32'h000000;
        px[2] = 32'h800001;
        run_frame(24, 3, 1'b1, 1'b0, "back_to_back");
    endtask

    task automatic test_starvation();
        px[0] = 32'h123456;
        run_frame(24, 1, 1'b0, 1'b0, "starve");
        px[0] = {8'h00, 24'($urandom)};
        run_frame(24, 1, 1'b1, 1'b0, "after_starve");
    endtask

    task automatic test_reset_midstream();
        logic [31:0] p;
        p     = {8'h00, 24'($urandom)};
        p[13] = 1'b1;
        valid = 1'b1;
        data  = p;
        last  = 1'b1;
        vectors++;
        if (ready_a !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_start_ready got %b want 1", ready_a);
        end
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (661) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (dout_a !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_dout_before got %b want 1", dout_a);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({dout_a, busy_a, ready_a} !== 3'b000) begin
            miscompares++;
            $display("FAIL midrst_async got dout/busy/ready=%b want 000", {dout_a, busy_a, ready_a});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (ready_a !== 1'b1 || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_release got ready/busy=%b%b want 10", ready_a, busy_a);
        end
        px[0] = {8'h00, 24'($urandom)};
        run_frame(24, 1, 1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_rgbw();
        sel   = 1'b1;
        px[0] = 32'h80000001;
        run_frame(32, 1, 1'b1, 1'b0, "rgbw");
        sel   = 1'b0;
    endtask

    task automatic test_latch_hold();
        px[0] = {8'h00, 24'($urandom)};
        run_frame(24, 1, 1'b1, 1'b1, "latch_hold");
        @(negedge clk);
        vectors++;
        if (busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL latch_hold_idle busy got %b want 0", busy_a);
        end
    endtask

    task automatic test_random();
        int n;
        bit fl;
        for (int k = 0; k < 4; k++) begin
            n  = int'($urandom_range(1, 3));
            fl = 1'($urandom);
            for (int i = 0; i < n; i++) px[i] = {8'h00, 24'($urandom)};
            run_frame(24, n, fl, 1'b0, "random");
        end
    endtask

    initial begin
        reset_n = 1'b0;
        valid   = 1'b0;
        data    = '0;
        last    = 1'b0;
        sel     = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_starvation();
        test_reset_midstream();
        test_rgbw();
        test_latch_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ws2812b_pixel_serializer.md
Name: ws2812b_pixel_serializer

Overview:
- Generalised successor of the single-bit NRZ code generator: accepts whole pixel words over a valid/ready handshake and serialises them MSB-first as WS2812B NRZ codes on one data line.
- Generates the inter-frame latch (reset) low period itself.
- Sits between the frame buffer / pixel fetch logic and the LED strip output pin.
- Pixel width is parametrised, so the same block drives 24-bit GRB and 32-bit RGBW parts.

Parameters:
- BITS_PER_PIXEL, 24: pixel word width; bits are sent MSB-first.
- BIT_PERIOD_CLKS, 63: clocks per code bit, high time plus low time.
- T0H_CLKS, 20: clocks dout is high for a 0-code.
- T1H_CLKS, 40: clocks dout is high for a 1-code.
- LATCH_CLKS, 2600: clocks dout is held low after a frame. At 50 MHz this is 52 us.
- Legal ranges: 1 <= T0H_CLKS < T1H_CLKS < BIT_PERIOD_CLKS; LATCH_CLKS >= BIT_PERIOD_CLKS; BITS_PER_PIXEL >= 2. Out-of-range values trigger an elaboration-time error.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pixel_data  in  BITS_PER_PIXEL  pixel word to send.
- pixel_last  in  1  qualifies pixel_data: this is the final pixel of the frame.
- pixel_valid  in  1  pixel_data and pixel_last are valid.
- pixel_ready  out  1  block accepts the word this cycle.
- dout  out  1  registered NRZ line to the strip.
- busy  out  1  high in SHIFT or LATCH.
- underflow  out  1  one-cycle pulse: pixel stream starved mid-frame.
- frame_done  out  1  one-cycle pulse: latch period completed.

Behaviour:
- Reset (async, reset_n = 0):
  - state = IDLE; all counters = 0.
  - dout, busy, underflow and frame_done = 0.
  - pixel_ready = 0 while reset is asserted.
  - pixel_ready goes to 1 on the first clk edge after release.
  - A reset mid-pixel or mid-latch aborts immediately; dout goes low asynchronously.
- Transfer rule: a word is accepted on any rising edge where pixel_valid && pixel_ready.
- State IDLE:
  - pixel_ready = 1; dout = 0.
  - On accept: load shift register, set bit_idx = BITS_PER_PIXEL-1, phase = 0, store pixel_last, then go to SHIFT.
  - dout rises on the edge after the accept edge. Accept-to-line latency is 1 cycle.
- State SHIFT:
  - phase counts 0..BIT_PERIOD_CLKS-1.
  - dout = 1 while phase < (current bit ? T1H_CLKS : T0H_CLKS), registered, so each code bit is exactly BIT_PERIOD_CLKS cycles wide.
  - At phase = BIT_PERIOD_CLKS-1, advance to the next bit (shift left, decrement bit_idx).
  - pixel_ready = 1 only in the final cycle of the final bit (bit_idx = 0, phase = BIT_PERIOD_CLKS-1), and only if the stored last flag = 0.
  - Accept in that cycle: the new pixel's first bit starts on the next edge. No gap between pixels.
  - End of final bit with last flag = 1: go to LATCH.
  - End of final bit with last flag = 0 and no accept: go to IDLE and pulse underflow for 1 cycle. dout stays low; the strip may latch early, and this is the system's responsibility.
- State LATCH:
  - dout = 0; pixel_ready = 0.
  - Counter runs 0..LATCH_CLKS-1.
  - At terminal count: pulse frame_done for 1 cycle and go to IDLE. IDLE can accept on the very next cycle.
- busy = (state != IDLE).
- A pixel_valid held without ready must not be consumed. pixel_data may change freely while not accepted.
- Counter widths:
  - phase: $clog2(BIT_PERIOD_CLKS).
  - latch counter: $clog2(LATCH_CLKS).
  - bit_idx: $clog2(BITS_PER_PIXEL).
  - No counter may wrap; each resets explicitly at its terminal value.
- Simultaneous events: a pixel_last word accepted back-to-back is handled like any pixel; LATCH begins after its final bit.

Decomposition:
- Shared package ws2812b_pkg holds:
  - state enum: IDLE, SHIFT, LATCH.
  - default timing constants: 50 MHz values for bit period, T0H, T1H and latch.
  - a function computing clock counts from nanoseconds and the clock frequency.
- One natural sub-module: ws2812b_bit_timer. It owns the phase counter and the high-time compare for one code bit, and emits bit_end. The top level owns the handshake, shift register, latch counter and FSM.

Test Plan:
- Single 24-bit pixel 0xA50F00 with pixel_last = 1:
  - 24 bit periods of 63 clocks each, with high times 40/20/40/20/20/40/20/40 … matching the bits.
  - Then dout low for exactly 2600 clocks.
  - frame_done pulses once; pixel_ready returns to 1 the same cycle.
- Back-to-back 3-pixel frame 0xFFFFFF, 0x000000, 0x800001, valid held high:
  - Each accept lands in the final cycle of the previous pixel.
  - dout shows no gap: total 72×63 clocks, then latch.
- Starvation: pixel 0x123456 with last = 0 and no further valid:
  - After 24×63 clocks, underflow pulses once, state returns to IDLE and dout = 0.
  - The next pixel starts 1 cycle after its accept.
- Reset mid-stream: assert reset_n = 0 at bit 10, phase 30 of a 1-code:
  - dout drops immediately; busy = 0.
  - After release, a fresh pixel is serialised from its MSB with correct timing.
- RGBW build, BITS_PER_PIXEL = 32, single pixel 0x80000001 with last = 1:
  - Exactly 32 code bits; the first and last are 1-codes (40 clocks high), the rest 0-codes (20 clocks high).
- Hold pixel_valid with changing data while in LATCH: pixel_ready stays 0 and no word is consumed until IDLE.
